// File: rtl/tile_pkg.sv
// tile_pkg: shared FSM states, pipeline constants and sizing helpers for tile_fetch
package tile_pkg;

    typedef enum logic [2:0] {IDLE, WAIT_TILE, FETCH, DRAIN, DONE} state_e;

    localparam int DRAIN_CYCLES   = 2;
    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_TILE_SIZE  = 4;

    function automatic int num_tiles(input int rows, input int cols, input int ts);
        return rows * cols / ts;
    endfunction

    // counter width for n distinct values, never below one bit
    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: tile/block/element counters and source-address arithmetic for tile_fetch
//   clk, rst           clock, synchronous active-high reset
//   clear              zero every counter (start of a pass)
//   step               advance one element, carrying into block, major and tile counters
//   tile               current tile number
//   addr               source address of the current element
//   elem_last          current element is the last of its tile
//   tile_last_of_pass  current tile is the final tile of the pass
//   TILE_FETCH_TRANSPOSE_EN selects column-segment tiles in column-major order.
module tile_addr_gen
    import tile_pkg::*;
#(
    parameter int TILE_SIZE  = DEF_TILE_SIZE,
    parameter int MAT_ROWS   = 8,
    parameter int MAT_COLS   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TW         = cw(num_tiles(MAT_ROWS, MAT_COLS, TILE_SIZE))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  step,
    output logic [TW-1:0]         tile,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  elem_last,
    output logic                  tile_last_of_pass
);

    localparam int NT = num_tiles(MAT_ROWS, MAT_COLS, TILE_SIZE);
`ifdef TILE_FETCH_TRANSPOSE_EN
    localparam int MAJ_N = MAT_COLS;
    localparam int BLK_N = MAT_ROWS / TILE_SIZE;
`else
    localparam int MAJ_N = MAT_ROWS;
    localparam int BLK_N = MAT_COLS / TILE_SIZE;
`endif
    localparam int MW = cw(MAJ_N);
    localparam int BW = cw(BLK_N);
    localparam int EW = cw(TILE_SIZE);
    localparam logic [ADDR_WIDTH-1:0] COLS_A = ADDR_WIDTH'(MAT_COLS);
    localparam logic [ADDR_WIDTH-1:0] TS_A   = ADDR_WIDTH'(TILE_SIZE);

    if (MAT_COLS % TILE_SIZE != 0) begin : g_cols_err
        $error("tile_addr_gen: MAT_COLS must be a multiple of TILE_SIZE");
    end
`ifdef TILE_FETCH_TRANSPOSE_EN
    if (MAT_ROWS % TILE_SIZE != 0) begin : g_rows_err
        $error("tile_addr_gen: MAT_ROWS must be a multiple of TILE_SIZE");
    end
`endif
    if (2 ** ADDR_WIDTH < MAT_ROWS * MAT_COLS) begin : g_addr_err
        $error("tile_addr_gen: ADDR_WIDTH too small for the matrix");
    end

    logic [TW-1:0] tile_q, tile_d;
    logic [MW-1:0] maj_q, maj_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [EW-1:0] elem_q, elem_d;
    logic          blk_last, maj_last;

    assign elem_last         = elem_q == EW'(TILE_SIZE - 1);
    assign blk_last          = blk_q == BW'(BLK_N - 1);
    assign maj_last          = maj_q == MW'(MAJ_N - 1);
    assign tile_last_of_pass = tile_q == TW'(NT - 1);
    assign tile              = tile_q;

    // major is the row (or column when transposed), block the segment within it
`ifdef TILE_FETCH_TRANSPOSE_EN
    assign addr = (ADDR_WIDTH'(blk_q) * TS_A + ADDR_WIDTH'(elem_q)) * COLS_A + ADDR_WIDTH'(maj_q);
`else
    assign addr = ADDR_WIDTH'(maj_q) * COLS_A + ADDR_WIDTH'(blk_q) * TS_A + ADDR_WIDTH'(elem_q);
`endif

    always_comb begin
        elem_d = elem_q;
        blk_d  = blk_q;
        maj_d  = maj_q;
        tile_d = tile_q;
        if (clear) begin
            elem_d = '0;
            blk_d  = '0;
            maj_d  = '0;
            tile_d = '0;
        end else if (step) begin
            elem_d = elem_last ? '0 : elem_q + 1'b1;
            blk_d  = !elem_last ? blk_q : blk_last ? '0 : blk_q + 1'b1;
            maj_d  = !(elem_last && blk_last) ? maj_q : maj_last ? '0 : maj_q + 1'b1;
            tile_d = !elem_last ? tile_q : tile_last_of_pass ? '0 : tile_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_q <= '0;
            blk_q  <= '0;
            maj_q  <= '0;
            tile_q <= '0;
        end else begin
            elem_q <= elem_d;
            blk_q  <= blk_d;
            maj_q  <= maj_d;
            tile_q <= tile_d;
        end
    end

endmodule

// File: rtl/tile_fetch.sv
// tile_fetch: streams a row-major source matrix into a tile buffer one tile at a time
//   clk, rst    clock, synchronous active-high reset
//   start       begin a matrix pass (only honoured when idle)
//   tile_ready  consumer can take the next whole tile
//   mem_rd_en   source memory read enable
//   mem_addr    source memory address, held while not reading
//   mem_rdata   source read data, one cycle after mem_rd_en
//   wr_en       element strobe to the tile buffer (two cycles after the read)
//   data_out    element to the tile buffer
//   tile_last   marks the last write of each tile
//   tile_idx    tile being emitted, updated on entry to FETCH
//   busy        pass in progress
//   done        one-cycle pulse at the end of a pass
//   TILE_FETCH_TRANSPOSE_EN selects column-segment tiles (see tile_addr_gen).
module tile_fetch
    import tile_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  TILE_SIZE  = DEF_TILE_SIZE,
    parameter int  MAT_ROWS   = 8,
    parameter int  MAT_COLS   = 8,
    parameter int  ADDR_WIDTH = 8,
    localparam int NUM_TILES  = num_tiles(MAT_ROWS, MAT_COLS, TILE_SIZE),
    localparam int TW         = cw(NUM_TILES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  tile_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  tile_last,
    output logic [TW-1:0]         tile_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int DCW = cw(DRAIN_CYCLES);

    state_e                state_q, state_d;
    logic [DCW-1:0]        drain_q, drain_d;
    logic                  final_q, final_d;
    logic [TW-1:0]         tile_idx_q, tile_idx_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  rd_d1_q, rd_d1_d;
    logic                  last_d1_q, last_d1_d;
    logic                  wr_en_q, wr_en_d;
    logic                  tile_last_q, tile_last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TW-1:0]         gen_tile;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  step, clear, elem_last, pass_last;

    tile_addr_gen #(
        .TILE_SIZE  (TILE_SIZE),
        .MAT_ROWS   (MAT_ROWS),
        .MAT_COLS   (MAT_COLS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TW         (TW)
    ) u_addr_gen (
        .clk               (clk),
        .rst               (rst),
        .clear             (clear),
        .step              (step),
        .tile              (gen_tile),
        .addr              (gen_addr),
        .elem_last         (elem_last),
        .tile_last_of_pass (pass_last)
    );

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        final_d    = final_q;
        tile_idx_d = tile_idx_q;
        step       = 1'b0;
        clear      = 1'b0;
        unique case (state_q)
            IDLE: begin
                clear   = start;
                state_d = start ? WAIT_TILE : IDLE;
            end
            WAIT_TILE: begin
                state_d    = tile_ready ? FETCH : WAIT_TILE;
                tile_idx_d = tile_ready ? gen_tile : tile_idx_q;
            end
            FETCH: begin
                step    = 1'b1;
                state_d = elem_last ? DRAIN : FETCH;
                drain_d = '0;
                // the counters wrap after the final element, so remember now whether this was the last tile
                final_d = elem_last ? pass_last : final_q;
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                state_d = drain_q != DCW'(DRAIN_CYCLES - 1) ? DRAIN : final_q ? DONE : WAIT_TILE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd_en = state_q == FETCH;
    assign mem_addr  = mem_rd_en ? gen_addr : mem_addr_q;

    // two-stage delay: stage one lines up with mem_rdata, stage two registers the write
    always_comb begin
        rd_d1_d     = mem_rd_en;
        last_d1_d   = mem_rd_en && elem_last;
        wr_en_d     = rd_d1_q;
        tile_last_d = last_d1_q;
        data_d      = rd_d1_q ? mem_rdata : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_q     <= '0;
            final_q     <= 1'b0;
            tile_idx_q  <= '0;
            mem_addr_q  <= '0;
            rd_d1_q     <= 1'b0;
            last_d1_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            tile_last_q <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            final_q     <= final_d;
            tile_idx_q  <= tile_idx_d;
            mem_addr_q  <= mem_addr;
            rd_d1_q     <= rd_d1_d;
            last_d1_q   <= last_d1_d;
            wr_en_q     <= wr_en_d;
            tile_last_q <= tile_last_d;
            data_q      <= data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign data_out  = data_q;
    assign tile_last = tile_last_q;
    assign tile_idx  = tile_idx_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;

endmodule

// File: tb/tb_tile_fetch.sv
// tb_tile_fetch: directed passes with random data/throttle against a tile-order reference model
module tb_tile_fetch;

    localparam int DW  = 12;
    localparam int TS  = 4;
    localparam int MR  = 8;
    localparam int MC  = 8;
    localparam int AW  = 8;
    localparam int NT  = MR * MC / TS;
    localparam int TOT = MR * MC;
    localparam int TW  = $clog2(NT);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          tile_ready = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          wr_en;
    logic [DW-1:0] data_out;
    logic          tile_last;
    logic [TW-1:0] tile_idx;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit ready_hist [0:8191];
    bit s_rst, s_start;
    bit in_pass = 1'b0;
    int w_cyc, done_cyc = -1, nrd = 0, nwr = 0;
    bit rd_m1 = 1'b0, rd_m2 = 1'b0;
    int addr_m1 = 0, addr_m2 = 0, last_addr = 0, exp_tidx = 0;

    tile_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tile_ready (tile_ready),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .wr_en      (wr_en),
        .data_out   (data_out),
        .tile_last  (tile_last),
        .tile_idx   (tile_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // address of the k-th element of a pass, straight from the tile ordering rules
    function automatic int exp_addr(input int k);
        int t = k / TS;
        int i = k % TS;
`ifdef TILE_FETCH_TRANSPOSE_EN
        return ((t % (MR / TS)) * TS + i) * MC + t / (MR / TS);
`else
        return (t / (MC / TS)) * MC + (t % (MC / TS)) * TS + i;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic observe();
        bit acc, exp_rd, exp_wr;
        if (s_rst) begin
            in_pass   = 1'b0;
            done_cyc  = -1;
            nrd       = 0;
            nwr       = 0;
            rd_m1     = 1'b0;
            rd_m2     = 1'b0;
            last_addr = 0;
            exp_tidx  = 0;
            chk("rst_rd_en", 32'(mem_rd_en), 0);
            chk("rst_addr", 32'(mem_addr), 0);
            chk("rst_wr_en", 32'(wr_en), 0);
            chk("rst_data", 32'(data_out), 0);
            chk("rst_tile_last", 32'(tile_last), 0);
            chk("rst_tile_idx", 32'(tile_idx), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            return;
        end
        acc = s_start && !in_pass;
        if (in_pass && done_cyc >= 0 && cyc > done_cyc) in_pass = 1'b0;
        if (acc) begin
            in_pass  = 1'b1;
            w_cyc    = cyc;
            done_cyc = -1;
            nrd      = 0;
            nwr      = 0;
        end
        chk("busy", 32'(busy), 32'(in_pass));
        chk("done", 32'(done), 32'(cyc == done_cyc));
        // a tile may begin once the FSM has waited and seen tile_ready; the rest of a tile has no bubbles
        exp_rd = in_pass && nrd < TOT && (nrd % TS != 0 || (cyc - 1 >= w_cyc && ready_hist[cyc-1]));
        chk("rd_en", 32'(mem_rd_en), 32'(exp_rd));
        if (exp_rd) begin
            if (nrd % TS == 0) exp_tidx = nrd / TS;
            last_addr = exp_addr(nrd);
            nrd++;
            if (nrd % TS == 0) w_cyc = cyc + 3;
            if (nrd == TOT) done_cyc = cyc + 3;
        end
        chk("mem_addr", 32'(mem_addr), last_addr);
        chk("tile_idx", 32'(tile_idx), exp_tidx);
        exp_wr = rd_m2;
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        chk("tile_last", 32'(tile_last), 32'(exp_wr && nwr % TS == TS - 1));
        if (exp_wr) begin
            chk("data_out", 32'(data_out), 32'(mem[addr_m2]));
            nwr++;
        end
        rd_m2   = rd_m1;
        addr_m2 = addr_m1;
        rd_m1   = exp_rd;
        addr_m1 = last_addr;
    endtask

    task automatic tick();
        if (cyc >= 8000) begin
            $display("FAIL cycle_budget cyc=%0d observed=over expected=under 8000", cyc);
            $fatal(1);
        end
        s_rst  = rst;
        s_start = start;
        ready_hist[cyc] = tile_ready;
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic finish_pass(input int bound);
        for (int n = 0; n < bound && in_pass; n++) tick();
        chk("pass_timeout", 32'(in_pass), 0);
        chk("pass_writes", nwr, TOT);
    endtask

    task automatic wait_nrd(input int target, input int bound);
        for (int n = 0; n < bound && nrd < target; n++) tick();
        chk("wait_reads", 32'(nrd >= target), 1);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = DW'(a);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tile_ready = 1'b1;
        tick();

        // identity memory, consumer always ready
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_pass(200);
        repeat (3) tick();

        // random data, consumer stalls 5 cycles before tile 3
        for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_nrd(3 * TS, 100);
        tile_ready = 1'b0;
        repeat (5) tick();
        tile_ready = 1'b1;
        finish_pass(200);
        tick();

        // start re-pulsed during tile 5 must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_nrd(5 * TS + 1, 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_pass(200);
        tick();

        // random throttle
        for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 2000 && in_pass; n++) begin
            tile_ready = $urandom_range(0, 2) != 0;
            tick();
        end
        tile_ready = 1'b1;
        chk("random_pass_timeout", 32'(in_pass), 0);
        chk("random_pass_writes", nwr, TOT);
        tick();

        // reset in the second FETCH cycle of tile 4, then a clean restart
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_nrd(4 * TS + 2, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_pass(200);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
